// File: rtl/wb_stage_reg_pkg.sv
// wb_stage_reg_pkg
//   Shared definitions for the writeback stage slice of the 64-bit core:
//   default bus / register-index widths (also used by the writeback mux and
//   the register file) and the names of the eight writeback source indices.
package wb_stage_reg_pkg;

    localparam int BUS_BITS_DEF = 64;
    localparam int RD_BITS_DEF  = 5;
    localparam int WB_SRC_NUM   = 8;

    // Index k here is both the one-hot bit position from the decoder and the
    // mux select value / candidate slot (slot 0 feeds mux in1).
    typedef enum logic [2:0] {
        WB_SRC_ALU   = 3'd0,
        WB_SRC_MEM   = 3'd1,
        WB_SRC_PC4   = 3'd2,
        WB_SRC_IMM   = 3'd3,
        WB_SRC_SHIFT = 3'd4,
        WB_SRC_MUL   = 3'd5,
        WB_SRC_SYS   = 3'd6,
        WB_SRC_SPARE = 3'd7
    } wb_src_e;

endpackage

// File: rtl/wb_stage_reg_if.sv
// wb_stage_reg_if
//   Bundles the MEM->WB pipeline register's control, capture and output
//   signals.
//   master : MEM-stage side (drives stall/flush/in_*, observes out_*)
//   slave  : the pipeline register itself
interface wb_stage_reg_if #(
    parameter int BUS_BITS = 64,
    parameter int RD_BITS  = 5
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  in_reg_write;
    logic [RD_BITS-1:0]    in_rd;
    logic [7:0]            in_wb_onehot;
    logic [8*BUS_BITS-1:0] in_cand;

    logic [8*BUS_BITS-1:0] out_cand;
    logic [2:0]            out_sel;
    logic                  out_valid;
    logic [RD_BITS-1:0]    out_rd;
    logic                  out_reg_write;
    logic                  onehot_err;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd, in_wb_onehot, in_cand,
        input  out_cand, out_sel, out_valid, out_rd, out_reg_write, onehot_err
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_onehot, in_cand,
        output out_cand, out_sel, out_valid, out_rd, out_reg_write, onehot_err
    );

endinterface

// File: rtl/wb_stage_reg_onehot8_encoder.sv
// onehot8_encoder
//   Combinational 8-bit one-hot to 3-bit index encoder.
//   onehot  : input field, bit k selects source k
//   idx     : encoded index; forced to 0 when the field is malformed
//   invalid : field has no bit set or more than one bit set
module onehot8_encoder (
    input  logic [7:0] onehot,
    output logic [2:0] idx,
    output logic       invalid
);

    logic [2:0] or_idx;

    // OR of the positions of all set bits; exact only for a true one-hot,
    // which is why it is masked by invalid below.
    always_comb begin
        or_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (onehot[k]) begin
                or_idx = or_idx | 3'(k);
            end
        end
    end

    // x & (x-1) clears the lowest set bit: nonzero means two or more bits set.
    assign invalid = (onehot == 8'd0) || ((onehot & (onehot - 8'd1)) != 8'd0);
    assign idx     = invalid ? 3'd0 : or_idx;

endmodule

// File: rtl/wb_stage_reg.sv
// wb_stage_reg
//   MEM/WB pipeline register feeding the 8-way writeback result mux.
//   Captures the eight candidate buses, destination index and write enable,
//   and encodes the decoder's one-hot source field into the mux select.
//   Edge priority: flush > stall > load. One cycle of latency, no
//   combinational path from any input to any output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of wb_stage_reg_if (stall/flush, in_*, out_*,
//           sticky onehot_err)
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int BUS_BITS    = BUS_BITS_DEF,
    parameter int RD_BITS     = RD_BITS_DEF,
    parameter int ZERO_REG    = 31,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_stage_reg_if.slave  bus
);

    logic [8*BUS_BITS-1:0] cand_q;
    wb_src_e               sel_q;
    logic                  valid_q;
    logic [RD_BITS-1:0]    rd_q;
    logic                  reg_write_q;
    logic                  err_q;

    logic [2:0]            enc_idx;
    logic                  enc_invalid;
    logic                  zero_hit;

    onehot8_encoder u_enc (
        .onehot  (bus.in_wb_onehot),
        .idx     (enc_idx),
        .invalid (enc_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= '0;
            sel_q       <= WB_SRC_ALU;
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.flush) begin
            // Bubble: candidates and rd are left as they were; only the
            // fields that make the entry live are cleared. The incoming
            // instruction is dropped, so its source field cannot flag an error.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            sel_q       <= WB_SRC_ALU;
        end else if (!bus.stall) begin
            cand_q      <= bus.in_cand;
            sel_q       <= wb_src_e'(enc_idx);
            valid_q     <= bus.in_valid;
            rd_q        <= bus.in_rd;
            reg_write_q <= bus.in_reg_write & bus.in_valid;
            if (bus.in_valid && enc_invalid) begin
                err_q <= 1'b1;
            end
        end
    end

    // Writes to the hard-wired zero register are suppressed after the
    // register so out_reg_write depends on registered state only.
    assign zero_hit = ZERO_REG_EN && (rd_q == RD_BITS'(ZERO_REG));

    assign bus.out_cand      = cand_q;
    assign bus.out_sel       = sel_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_reg_write = reg_write_q & valid_q & ~zero_hit;
    assign bus.onehot_err    = err_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

    localparam int BB = 64;
    localparam int RB = 5;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    wb_stage_reg_if #(.BUS_BITS(BB), .RD_BITS(RB)) bus_a ();
    wb_stage_reg_if #(.BUS_BITS(BB), .RD_BITS(RB)) bus_b ();

    wb_stage_reg #(.BUS_BITS(BB), .RD_BITS(RB), .ZERO_REG(31), .ZERO_REG_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    wb_stage_reg #(.BUS_BITS(BB), .RD_BITS(RB), .ZERO_REG(31), .ZERO_REG_EN(1'b0)) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic [2:0]      sel;
        logic [RB-1:0]   rd;
        logic            wr;
        logic            wr_nz;
        logic            err;
        logic [8*BB-1:0] cand;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic            m_valid;
    logic [2:0]      m_sel;
    logic [RB-1:0]   m_rd;
    logic            m_rw;
    logic            m_err;
    logic [8*BB-1:0] m_cand;

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 3'd0;
        m_rd    = '0;
        m_rw    = 1'b0;
        m_err   = 1'b0;
        m_cand  = '0;
        exp_q.delete();
    endtask

    function automatic logic [8*BB-1:0] rand_cand();
        logic [8*BB-1:0] c;
        for (int i = 0; i < (8*BB)/32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic [RB-1:0] rd, input logic [7:0] oh,
                         input logic [8*BB-1:0] cand);
        bus_a.stall = st;  bus_b.stall = st;
        bus_a.flush = fl;  bus_b.flush = fl;
        bus_a.in_valid = v;  bus_b.in_valid = v;
        bus_a.in_reg_write = rw;  bus_b.in_reg_write = rw;
        bus_a.in_rd = rd;  bus_b.in_rd = rd;
        bus_a.in_wb_onehot = oh;  bus_b.in_wb_onehot = oh;
        bus_a.in_cand = cand;  bus_b.in_cand = cand;
    endtask

    // One cycle: drive at negedge, update model and push expectation,
    // then pop and compare just after the rising edge.
    task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                        input logic [RB-1:0] rd, input logic [7:0] oh,
                        input logic [8*BB-1:0] cand);
        exp_t e;
        @(negedge clk);
        drive(st, fl, v, rw, rd, oh, cand);
        if (fl) begin
            m_valid = 1'b0;
            m_rw    = 1'b0;
            m_sel   = 3'd0;
        end else if (!st) begin
            m_valid = v;
            m_rw    = rw & v;
            m_rd    = rd;
            m_cand  = cand;
            if ($countones(oh) == 1) m_sel = 3'($clog2(oh));
            else                     m_sel = 3'd0;
            if (v && ($countones(oh) != 1)) m_err = 1'b1;
        end
        e.valid = m_valid;
        e.sel   = m_sel;
        e.rd    = m_rd;
        e.wr    = m_rw & m_valid & (m_rd != 5'd31);
        e.wr_nz = m_rw & m_valid;
        e.err   = m_err;
        e.cand  = m_cand;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus_a.out_valid !== e.valid) begin
            errors++; $display("FAIL out_valid got %0b exp %0b t=%0t", bus_a.out_valid, e.valid, $time);
        end
        checks++;
        if (bus_a.out_sel !== e.sel) begin
            errors++; $display("FAIL out_sel got %0d exp %0d t=%0t", bus_a.out_sel, e.sel, $time);
        end
        checks++;
        if (bus_a.out_rd !== e.rd) begin
            errors++; $display("FAIL out_rd got %0d exp %0d t=%0t", bus_a.out_rd, e.rd, $time);
        end
        checks++;
        if (bus_a.out_reg_write !== e.wr) begin
            errors++; $display("FAIL out_reg_write got %0b exp %0b t=%0t", bus_a.out_reg_write, e.wr, $time);
        end
        checks++;
        if (bus_b.out_reg_write !== e.wr_nz) begin
            errors++; $display("FAIL out_reg_write_nozero got %0b exp %0b t=%0t", bus_b.out_reg_write, e.wr_nz, $time);
        end
        checks++;
        if (bus_a.onehot_err !== e.err) begin
            errors++; $display("FAIL onehot_err got %0b exp %0b t=%0t", bus_a.onehot_err, e.err, $time);
        end
        checks++;
        if (bus_a.out_cand !== e.cand) begin
            errors++; $display("FAIL out_cand mismatch in at least one slice t=%0t", $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus_a.out_cand !== '0 || bus_a.out_sel !== 3'd0 || bus_a.out_valid !== 1'b0 ||
            bus_a.out_rd !== '0 || bus_a.out_reg_write !== 1'b0 || bus_a.onehot_err !== 1'b0 ||
            bus_b.out_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs not zero: sel %0d valid %0b rd %0d wr %0b err %0b (expected all 0)",
                     tag, bus_a.out_sel, bus_a.out_valid, bus_a.out_rd, bus_a.out_reg_write, bus_a.onehot_err);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h01, '0);
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 8'h04, rand_cand());
        // Assert reset mid-stall, between edges, and look before any edge.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 8'h10, rand_cand());
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_load();
        logic [8*BB-1:0] c;
        c = rand_cand();
        c[5*BB +: BB] = 64'hDEAD_BEEF;
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 8'h20, c);
        checks++;
        if (bus_a.out_cand[5*BB +: BB] !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL cand5 got %h exp %h", bus_a.out_cand[5*BB +: BB], 64'hDEAD_BEEF);
        end
    endtask

    task automatic test_stall_flush();
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 8'h08, rand_cand());
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, $urandom_range(0, 1), 1'b1, 5'($urandom), 8'h81, rand_cand());
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 8'h03, rand_cand());
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 8'h00, rand_cand());
    endtask

    task automatic test_zero_reg();
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 8'h01, rand_cand());
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd30, 8'h02, rand_cand());
    endtask

    task automatic test_malformed_not_valid();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 8'h03, rand_cand());
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'h00, rand_cand());
    endtask

    task automatic test_malformed();
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 8'h03, rand_cand());
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'($urandom), 8'(1 << (i % 8)), rand_cand());
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'(k + 1), 8'(1 << k), rand_cand());
    endtask

    task automatic test_random();
        logic [7:0] oh;
        for (int i = 0; i < 60; i++) begin
            oh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), 5'($urandom), oh, rand_cand());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        test_reset();
        test_normal_load();
        test_stall_flush();
        test_zero_reg();
        test_malformed_not_valid();
        test_malformed();
        test_back_to_back();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
